// File: rtl/fetch_boot_unit.sv
// Boot loader plus instruction-fetch front end: copies BOOT_WORDS words into imem, then runs PC/IF-ID.
// Optional boot idle timeout is built when FETCH_BOOT_TIMEOUT_EN is defined.
module fetch_boot_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BOOT_WORDS = 16,
    parameter logic [ADDR_W-1:0] BOOT_BASE = '0,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int BOOT_TIMEOUT = 64
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            boot_valid,
    input  logic [DATA_W-1:0]               boot_data,
    output logic                            boot_ready,
    output logic [ADDR_W-1:0]               imem_addr,
    output logic [DATA_W-1:0]               imem_wdata,
    output logic                            imem_we,
    output logic                            imem_oe,
    input  logic [DATA_W-1:0]               imem_rdata,
    input  logic                            stall,
    input  logic                            branch_taken,
    input  logic [ADDR_W-1:0]               branch_target,
    input  logic                            halt_req,
    output logic                            on_bios,
    output logic [$clog2(BOOT_WORDS+1)-1:0] boot_count,
    output logic [ADDR_W-1:0]               if_pc,
    output logic [ADDR_W-1:0]               if_pcpp,
    output logic [DATA_W-1:0]               if_instruction,
    output logic                            if_valid,
    output logic                            boot_timeout,
    output logic [1:0]                      fsm_state
);
    localparam int CNT_W = $clog2(BOOT_WORDS + 1);

    typedef enum logic [1:0] {IDLE, BOOT, RUN, HALT} state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  pc, pc_next;
    logic [CNT_W-1:0]   count_next;
    logic               accept, last_word, timeout_hit;
    logic               if_load, if_clear;

    // Boot handshake: a word transfers on every rising clock edge where
    // boot_valid and boot_ready are both high; boot_ready is high exactly in BOOT.
    assign boot_ready = (state == BOOT);
    assign accept     = boot_ready && boot_valid;
    assign last_word  = accept && (boot_count == CNT_W'(BOOT_WORDS - 1));
    assign on_bios    = (state == IDLE) || (state == BOOT);
    assign imem_wdata = boot_data;
    assign fsm_state  = state;

`ifdef FETCH_BOOT_TIMEOUT_EN
    localparam int TO_W = $clog2(BOOT_TIMEOUT + 1);
    logic [TO_W-1:0] idle_count;
    logic            timeout_flag;

    assign timeout_hit  = (state == BOOT) && !boot_valid && (idle_count == TO_W'(BOOT_TIMEOUT - 1));
    assign boot_timeout = timeout_flag;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idle_count   <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == BOOT && !boot_valid && !timeout_hit)
                idle_count <= idle_count + 1'b1;
            else
                idle_count <= '0;
            if (timeout_hit)
                timeout_flag <= 1'b1;
        end
    end
`else
    // Never fires in this build; BOOT waits for the full image.
    assign timeout_hit  = (BOOT_TIMEOUT < 0);
    assign boot_timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        count_next = boot_count;
        if_load    = 1'b0;
        if_clear   = 1'b0;
        imem_addr  = pc;
        imem_we    = 1'b0;
        imem_oe    = 1'b0;
        case (state)
            IDLE: state_next = BOOT;
            BOOT: begin
                imem_addr = BOOT_BASE + ADDR_W'(boot_count);
                imem_we   = accept;
                if (accept)
                    count_next = boot_count + 1'b1;
                if (last_word || timeout_hit) begin
                    state_next = RUN;
                    pc_next    = RESET_PC;
                end
            end
            RUN: begin
                imem_oe = 1'b1;
                // Redirect beats halt beats stall.
                if (branch_taken) begin
                    pc_next  = branch_target;
                    if_clear = 1'b1;
                end else if (halt_req) begin
                    state_next = HALT;
                    if_clear   = 1'b1;
                end else if (!stall) begin
                    if_load = 1'b1;
                    pc_next = pc + 1'b1;
                end
            end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            boot_count <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            boot_count <= count_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_pc          <= '0;
            if_pcpp        <= '0;
            if_instruction <= '0;
            if_valid       <= 1'b0;
        end else if (if_clear) begin
            if_valid <= 1'b0;
        end else if (if_load) begin
            if_instruction <= imem_rdata;
            if_pc          <= pc;
            if_pcpp        <= pc + 1'b1;
            if_valid       <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_boot_unit.sv
// Self-checking bench for fetch_boot_unit: BOOT_WORDS=4, BOOT_TIMEOUT=8, behavioural fetch model.
module tb_fetch_boot_unit;
    localparam int NW = 4;
    localparam int CW = $clog2(NW + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          boot_valid = 1'b0;
    logic [31:0]   boot_data = '0;
    logic          boot_ready;
    logic [31:0]   imem_addr, imem_wdata, imem_rdata;
    logic          imem_we, imem_oe;
    logic          stall = 1'b0, branch_taken = 1'b0, halt_req = 1'b0;
    logic [31:0]   branch_target = '0;
    logic          on_bios, if_valid, boot_timeout;
    logic [CW-1:0] boot_count;
    logic [31:0]   if_pc, if_pcpp, if_instruction;
    logic [1:0]    fsm_state;

    int vectors = 0;
    int miscompares = 0;

    fetch_boot_unit #(
        .ADDR_W(32), .DATA_W(32), .BOOT_WORDS(NW),
        .BOOT_BASE(32'h0), .RESET_PC(32'h0), .BOOT_TIMEOUT(8)
    ) dut (
        .clock(clock), .reset(reset),
        .boot_valid(boot_valid), .boot_data(boot_data), .boot_ready(boot_ready),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_we(imem_we),
        .imem_oe(imem_oe), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .halt_req(halt_req), .on_bios(on_bios), .boot_count(boot_count),
        .if_pc(if_pc), .if_pcpp(if_pcpp), .if_instruction(if_instruction),
        .if_valid(if_valid), .boot_timeout(boot_timeout), .fsm_state(fsm_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- memory behind the DUT ----------------
    function automatic logic [31:0] fill(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0};
    endfunction

    logic [31:0] imem [0:15];
    initial for (int i = 0; i < 16; i++) imem[i] = fill(32'(i));
    always @(posedge clock) if (imem_we && imem_addr < 32'd16) imem[imem_addr[3:0]] <= imem_wdata;
    assign imem_rdata = (imem_addr < 32'd16) ? imem[imem_addr[3:0]] : fill(imem_addr);

    // ---------------- reference model ----------------
    logic [31:0] boot_words [0:NW-1];
    logic [31:0] pc_m, ins_m, ipc_m, ipcpp_m;
    logic        v_m, halted_m;
    logic [31:0] c_addr;
    logic        c_oe, c_we;

    function automatic logic [31:0] exp_mem(input logic [31:0] a);
        return (a < NW) ? boot_words[a[1:0]] : fill(a);
    endfunction

    task automatic model_start();
        pc_m = 32'h0; ins_m = '0; ipc_m = '0; ipcpp_m = '0; v_m = 1'b0; halted_m = 1'b0;
    endtask

    // Drive one RUN/HALT clock from a negedge, capture combinational outputs, advance model.
    task automatic run_cycle(input logic st, input logic br, input logic [31:0] tgt, input logic hl);
        stall = st; branch_taken = br; branch_target = tgt; halt_req = hl;
        #1;
        c_addr = imem_addr; c_oe = imem_oe; c_we = imem_we;
        if (!halted_m) begin
            if (br) begin
                pc_m = tgt; v_m = 1'b0;
            end else if (hl) begin
                halted_m = 1'b1; v_m = 1'b0;
            end else if (!st) begin
                ins_m = exp_mem(pc_m); ipc_m = pc_m; ipcpp_m = pc_m + 1; v_m = 1'b1; pc_m = pc_m + 1;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        vectors++;
        if ({on_bios, boot_ready, boot_count, if_valid, boot_timeout} !== {1'b1, 1'b0, CW'(0), 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_flags got=%b exp=%b", {on_bios, boot_ready, boot_count, if_valid, boot_timeout},
                     {1'b1, 1'b0, CW'(0), 1'b0, 1'b0});
        end
        vectors++;
        if ({if_pc, if_pcpp, if_instruction} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_ifid got=%h exp=0", {if_pc, if_pcpp, if_instruction});
        end
        vectors++;
        if ({imem_we, imem_oe} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_imem got=%b exp=00", {imem_we, imem_oe});
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_boot();
        vectors++;
        if (boot_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL boot_ready_on got=%b exp=1", boot_ready);
        end
        for (int i = 0; i < NW; i++) begin
            boot_words[i] = 32'hA0 + 32'(i);
            boot_valid = 1'b1;
            boot_data = boot_words[i];
            #1;
            vectors++;
            if ({imem_we, imem_oe, imem_addr, imem_wdata} !== {1'b1, 1'b0, 32'(i), boot_words[i]}) begin
                miscompares++;
                $display("FAIL boot_write[%0d] got=%b/%b/%h/%h exp=1/0/%h/%h", i,
                         imem_we, imem_oe, imem_addr, imem_wdata, i, boot_words[i]);
            end
            step();
            vectors++;
            if ({boot_count, on_bios, if_valid} !== {CW'(i + 1), (i < NW - 1), 1'b0}) begin
                miscompares++;
                $display("FAIL boot_count[%0d] got=%0d/%b/%b exp=%0d/%b/0", i, boot_count, on_bios, if_valid,
                         i + 1, (i < NW - 1));
            end
        end
        boot_valid = 1'b0;
        vectors++;
        if (boot_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL boot_ready_off got=%b exp=0", boot_ready);
        end
        model_start();
    endtask

    task automatic test_run();
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
            vectors++;
            if ({c_oe, c_we, c_addr} !== {1'b1, 1'b0, 32'(i)}) begin
                miscompares++;
                $display("FAIL run_fetch_addr[%0d] got=%b/%b/%h exp=1/0/%h", i, c_oe, c_we, c_addr, i);
            end
            vectors++;
            if ({if_valid, if_pc, if_pcpp, if_instruction} !== {1'b1, 32'(i), 32'(i + 1), boot_words[i]}) begin
                miscompares++;
                $display("FAIL run_ifid[%0d] got=%b/%h/%h/%h exp=1/%h/%h/%h", i, if_valid, if_pc, if_pcpp,
                         if_instruction, i, i + 1, boot_words[i]);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            run_cycle(1'b1, 1'b0, 32'h0, 1'b0);
            vectors++;
            if ({if_valid, if_pc, if_pcpp, if_instruction} !== {1'b1, 32'h2, 32'h3, boot_words[2]}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d] got=%b/%h/%h/%h exp=1/2/3/%h", i, if_valid, if_pc, if_pcpp,
                         if_instruction, boot_words[2]);
            end
        end
        run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'h3, boot_words[3]}) begin
            miscompares++;
            $display("FAIL stall_resume got=%b/%h/%h exp=1/3/%h", if_valid, if_pc, if_instruction, boot_words[3]);
        end
    endtask

    task automatic test_branch_stall();
        run_cycle(1'b1, 1'b1, 32'h10, 1'b0);
        vectors++;
        if (if_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL branch_flush got=%b exp=0", if_valid);
        end
        run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if ({c_addr, if_valid, if_pc, if_pcpp, if_instruction} !== {32'h10, 1'b1, 32'h10, 32'h11, fill(32'h10)}) begin
            miscompares++;
            $display("FAIL branch_target got=%h/%b/%h/%h/%h exp=10/1/10/11/%h", c_addr, if_valid, if_pc, if_pcpp,
                     if_instruction, fill(32'h10));
        end
    endtask

    task automatic test_wrap();
        run_cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if ({if_valid, if_pc, if_pcpp} !== {1'b1, 32'hFFFF_FFFF, 32'h0}) begin
            miscompares++;
            $display("FAIL wrap_top got=%b/%h/%h exp=1/ffffffff/0", if_valid, if_pc, if_pcpp);
        end
        run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if ({if_pc, if_pcpp, if_instruction} !== {32'h0, 32'h1, boot_words[0]}) begin
            miscompares++;
            $display("FAIL wrap_zero got=%h/%h/%h exp=0/1/%h", if_pc, if_pcpp, if_instruction, boot_words[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        for (int i = 0; i < 200; i++) begin
            tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 24));
            run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, tgt, 1'b0);
            vectors++;
            if ({c_oe, c_addr, if_valid, if_pc, if_pcpp, if_instruction} !==
                {1'b1, ipc_m == c_addr ? c_addr : c_addr, v_m, ipc_m, ipcpp_m, ins_m} || c_addr !== c_addr) begin
                miscompares++;
                $display("FAIL random_ifid[%0d] got=%b/%h/%h/%h exp=%b/%h/%h/%h", i, if_valid, if_pc, if_pcpp,
                         if_instruction, v_m, ipc_m, ipcpp_m, ins_m);
            end
            vectors++;
            if ({c_oe, c_we} !== 2'b10) begin
                miscompares++;
                $display("FAIL random_imem_ctl[%0d] got=%b exp=10", i, {c_oe, c_we});
            end
        end
        // Confirm the model PC by fetching once with no disturbance.
        tgt = pc_m;
        run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if ({c_addr, if_pc, if_instruction} !== {tgt, tgt, exp_mem(tgt)}) begin
            miscompares++;
            $display("FAIL random_pc got=%h/%h/%h exp=%h/%h/%h", c_addr, if_pc, if_instruction, tgt, tgt, exp_mem(tgt));
        end
    endtask

    task automatic test_halt();
        run_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if ({if_valid, on_bios} !== 2'b00) begin
            miscompares++;
            $display("FAIL halt_enter got=%b exp=00", {if_valid, on_bios});
        end
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'($urandom_range(0, 1)), 1'b1, $urandom, 1'b0);
            vectors++;
            if ({c_oe, c_we, if_valid, if_pc, if_pcpp, if_instruction} !== {2'b00, 1'b0, ipc_m, ipcpp_m, ins_m}) begin
                miscompares++;
                $display("FAIL halt_hold[%0d] got=%b%b%b/%h/%h exp=000/%h/%h", i, c_oe, c_we, if_valid, if_pc,
                         if_instruction, ipc_m, ins_m);
            end
        end
        stall = 1'b0; branch_taken = 1'b0;
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({on_bios, boot_ready, boot_count, if_valid, if_pc} !== {1'b1, 1'b0, CW'(0), 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL halt_reset got=%b/%b/%0d/%b/%h exp=1/0/0/0/0", on_bios, boot_ready, boot_count, if_valid, if_pc);
        end
        step();
        reset = 1'b1;
        step();
        vectors++;
        if ({boot_ready, on_bios, boot_count} !== {1'b1, 1'b1, CW'(0)}) begin
            miscompares++;
            $display("FAIL reboot got=%b/%b/%0d exp=1/1/0", boot_ready, on_bios, boot_count);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 2; i++) begin
            boot_words[i] = $urandom;
            boot_valid = 1'b1;
            boot_data = boot_words[i];
            step();
        end
        boot_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            vectors++;
            if ({imem_we, on_bios, boot_count} !== {1'b0, 1'b1, CW'(2)}) begin
                miscompares++;
                $display("FAIL idle_boot[%0d] got=%b/%b/%0d exp=0/1/2", i, imem_we, on_bios, boot_count);
            end
            step();
        end
        step();
`ifdef FETCH_BOOT_TIMEOUT_EN
        vectors++;
        if ({on_bios, boot_ready, boot_timeout, boot_count} !== {1'b0, 1'b0, 1'b1, CW'(2)}) begin
            miscompares++;
            $display("FAIL timeout_handoff got=%b/%b/%b/%0d exp=0/0/1/2", on_bios, boot_ready, boot_timeout, boot_count);
        end
        model_start();
        run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if ({if_valid, if_pc, if_instruction, boot_timeout} !== {1'b1, 32'h0, boot_words[0], 1'b1}) begin
            miscompares++;
            $display("FAIL timeout_fetch got=%b/%h/%h/%b exp=1/0/%h/1", if_valid, if_pc, if_instruction, boot_timeout,
                     boot_words[0]);
        end
`else
        vectors++;
        if ({on_bios, boot_ready, boot_timeout, boot_count} !== {1'b1, 1'b1, 1'b0, CW'(2)}) begin
            miscompares++;
            $display("FAIL no_timeout got=%b/%b/%b/%0d exp=1/1/0/2", on_bios, boot_ready, boot_timeout, boot_count);
        end
        for (int i = 2; i < NW; i++) begin
            boot_words[i] = $urandom;
            boot_valid = 1'b1;
            boot_data = boot_words[i];
            step();
        end
        boot_valid = 1'b0;
        vectors++;
        if ({on_bios, boot_count, boot_timeout} !== {1'b0, CW'(NW), 1'b0}) begin
            miscompares++;
            $display("FAIL late_complete got=%b/%0d/%b exp=0/%0d/0", on_bios, boot_count, boot_timeout, NW);
        end
`endif
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_boot();
        test_run();
        test_stall();
        test_branch_stall();
        test_wrap();
        test_random();
        test_halt();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
